iiitb_vm_dispenser: RTL and testbench

//  Actuator side of the vending FSM: consumes its per-cycle vend/change codes and

---
 rtl/iiitb_vm_pkg.sv | 38 +++
 rtl/iiitb_vm_pulse_timer.sv | 30 +++
 rtl/iiitb_vm_dispenser.sv | 218 +++++++++++++++++++++
 tb/tb_iiitb_vm_dispenser.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_vm_pkg.sv
// Shared definitions for the vending-machine dispenser: state encodings,
// change-request codes and default mechanism timing.
package iiitb_vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VEND = 3'd1,
    ST_C10  = 3'd2,
    ST_G10  = 3'd3,
    ST_C5   = 3'd4,
    ST_G5   = 3'd5,
    ST_DONE = 3'd6
  } vm_state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  localparam int unsigned VEND_PULSE_DEF = 32'd8;
  localparam int unsigned COIN_PULSE_DEF = 32'd4;
  localparam int unsigned COIN_GAP_DEF   = 32'd2;
  localparam int unsigned TIMEOUT_DEF    = 32'd64;

  // Change is paid largest coin first; with nothing owed we go straight to DONE.
  function automatic vm_state_t first_change_state(input logic [1:0] chg);
    vm_state_t st;
    case (chg)
      CHG_15:   st = ST_C10;
      CHG_10:   st = ST_C10;
      CHG_5:    st = ST_C5;
      CHG_NONE: st = ST_DONE;
      default:  st = ST_DONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/iiitb_vm_pulse_timer.sv
// Loadable saturating cycle counter. Cleared whenever the controller changes
// state so that every interval (motor, coin, gap, timeout) starts from zero.
module iiitb_vm_pulse_timer #(
  parameter int unsigned W = 32'd7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/iiitb_vm_dispenser.sv
// Dispenser actuator controller: turns one vend/change request from the
// vending FSM into a timed motor pulse followed by 10- and 5-unit coin pulses.
// All drive outputs are registered copies of the next-state decode, so they
// never follow the inputs combinationally.
module iiitb_vm_dispenser
  import iiitb_vm_pkg::*;
#(
  parameter int unsigned VEND_PULSE = VEND_PULSE_DEF,
  parameter int unsigned COIN_PULSE = COIN_PULSE_DEF,
  parameter int unsigned COIN_GAP   = COIN_GAP_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       out_req,
  input  logic [1:0] change_req,
  input  logic       vend_sense,
  input  logic       fault_clr,
  output logic       vend_motor,
  output logic       coin10_eject,
  output logic       coin5_eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  // The counter reads 0 in the first cycle of a state, so an interval of N
  // cycles ends on the cycle where it reads N-1.
  localparam logic [CW-1:0] VEND_LAST = CW'(VEND_PULSE - 1);
  localparam logic [CW-1:0] COIN_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(COIN_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  vm_state_t     state_r;
  vm_state_t     state_nxt_s;
  logic          vend_r;
  logic [1:0]    chg_r;
  logic [2:0]    prev_r;
  logic          sense_r;
  logic          fault_r;
  logic          overrun_r;
  logic [CW-1:0] cnt_s;
  logic [2:0]    code_s;
  logic          new_req_s;
  logic          sensed_s;
  logic          timeout_s;
  logic          state_chg_s;

  assign code_s      = {out_req, change_req};
  // A held code is a single request: only a change to a non-idle code counts.
  assign new_req_s   = (code_s != {1'b0, CHG_NONE}) && (code_s != prev_r);
  assign sensed_s    = sense_r | vend_sense;
  assign state_chg_s = (state_nxt_s != state_r);
  assign fault       = fault_r;
  assign overrun     = overrun_r;

  iiitb_vm_pulse_timer #(
    .W (CW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clr      (state_chg_s),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (1'b1),
    .cnt      (cnt_s)
  );

  // Next-state logic for the dispense sequence, plus the vend-timeout event.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (new_req_s) begin
          if (out_req) begin
            state_nxt_s = ST_VEND;
          end else if (change_req[1]) begin
            state_nxt_s = ST_C10;
          end else begin
            state_nxt_s = ST_C5;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_VEND: begin
        if ((cnt_s >= VEND_LAST) && sensed_s) begin
          state_nxt_s = first_change_state(chg_r);
        end else if (cnt_s >= TO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = first_change_state(chg_r);
        end else begin
          state_nxt_s = ST_VEND;
        end
      end
      ST_C10: begin
        if (cnt_s >= COIN_LAST) begin
          state_nxt_s = ST_G10;
        end else begin
          state_nxt_s = ST_C10;
        end
      end
      ST_G10: begin
        if (cnt_s >= GAP_LAST) begin
          state_nxt_s = chg_r[0] ? ST_C5 : ST_DONE;
        end else begin
          state_nxt_s = ST_G10;
        end
      end
      ST_C5: begin
        if (cnt_s >= COIN_LAST) begin
          state_nxt_s = ST_G5;
        end else begin
          state_nxt_s = ST_C5;
        end
      end
      ST_G5: begin
        if (cnt_s >= GAP_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_G5;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the accepted request, the previous input code and the drop sensor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vend_r  <= 1'b0;
      chg_r   <= CHG_NONE;
      prev_r  <= 3'b000;
      sense_r <= 1'b0;
    end else begin
      prev_r <= code_s;
      if ((state_r == ST_IDLE) && new_req_s) begin
        vend_r <= out_req;
        chg_r  <= change_req;
      end else begin
        vend_r <= vend_r;
        chg_r  <= chg_r;
      end
      if (state_r != ST_VEND) begin
        sense_r <= 1'b0;
      end else if (vend_sense) begin
        sense_r <= 1'b1;
      end else begin
        sense_r <= sense_r;
      end
    end
  end

  // Sticky error flags; a new set event takes priority over fault_clr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (timeout_s) begin
        fault_r <= 1'b1;
      end else if (fault_clr) begin
        fault_r <= 1'b0;
      end else begin
        fault_r <= fault_r;
      end
      if (new_req_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end else if (fault_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Registered Moore outputs: decode of the state about to be entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vend_motor   <= 1'b0;
      coin10_eject <= 1'b0;
      coin5_eject  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      vend_motor   <= (state_nxt_s == ST_VEND);
      coin10_eject <= (state_nxt_s == ST_C10);
      coin5_eject  <= (state_nxt_s == ST_C5);
      busy         <= (state_nxt_s != ST_IDLE);
      done         <= (state_nxt_s == ST_DONE);
    end
  end

  // vend_r records whether the accepted request included a product; the
  // sequence itself is already encoded in the state, so it is kept only for
  // observability and is otherwise unused.
  logic vend_unused_s;
  assign vend_unused_s = vend_r;

endmodule

// File: tb/tb_iiitb_vm_dispenser.sv
// Self-checking bench for iiitb_vm_dispenser. Expected per-cycle outputs come
// from a duration-based model: motor time from the sensor/timeout rule, then
// fixed coin and gap lengths, then one done cycle.
module tb_iiitb_vm_dispenser;

  localparam int VP = 8;
  localparam int CP = 4;
  localparam int CG = 2;
  localparam int TO = 64;

  // Per-cycle code layout: {motor, coin10, coin5, busy, done}
  localparam logic [4:0] E_MOTOR = 5'b10010;
  localparam logic [4:0] E_C10   = 5'b01010;
  localparam logic [4:0] E_C5    = 5'b00110;
  localparam logic [4:0] E_GAP   = 5'b00010;
  localparam logic [4:0] E_DONE  = 5'b00011;
  localparam logic [4:0] E_IDLE  = 5'b00000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       out_req = 1'b0;
  logic [1:0] change_req = 2'b00;
  logic       vend_sense = 1'b0;
  logic       fault_clr = 1'b0;
  logic       vend_motor, coin10_eject, coin5_eject, busy, done, fault, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_fault   = 1'b0;
  bit m_overrun = 1'b0;
  bit last_to;
  logic [4:0] obs[$];
  logic [4:0] expq[$];

  iiitb_vm_dispenser dut (
    .clock        (clock),
    .reset        (reset),
    .out_req      (out_req),
    .change_req   (change_req),
    .vend_sense   (vend_sense),
    .fault_clr    (fault_clr),
    .vend_motor   (vend_motor),
    .coin10_eject (coin10_eject),
    .coin5_eject  (coin5_eject),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Model: build the expected output code for every cycle after acceptance.
  task automatic build_expect(input bit v, input bit [1:0] c, input int s);
    int d;
    expq.delete();
    last_to = 1'b0;
    if (v) begin
      if (s >= 1 && s <= TO) d = (s > VP) ? s : VP;
      else begin d = TO; last_to = 1'b1; end
      repeat (d) expq.push_back(E_MOTOR);
    end
    if (c[1]) begin
      repeat (CP) expq.push_back(E_C10);
      repeat (CG) expq.push_back(E_GAP);
    end
    if (c[0]) begin
      repeat (CP) expq.push_back(E_C5);
      repeat (CG) expq.push_back(E_GAP);
    end
    expq.push_back(E_DONE);
    expq.push_back(E_IDLE);
    expq.push_back(E_IDLE);
  endtask

  // Drive one request (held for 'hold' cycles), optional sensor pulse and an
  // optional one-cycle injected code, capturing outputs each cycle.
  // Must be entered at a falling edge with idle inputs.
  task automatic run_txn(input bit v, input bit [1:0] c, input int s, input int hold,
                         input int inj_at, input logic [2:0] inj_code);
    obs.delete();
    out_req = v; change_req = c;
    for (int cyc = 1; cyc <= expq.size(); cyc++) begin
      @(negedge clock);
      obs.push_back({vend_motor, coin10_eject, coin5_eject, busy, done});
      if (cyc >= hold) begin out_req = 1'b0; change_req = 2'b00; end
      if (cyc == inj_at) {out_req, change_req} = inj_code;
      vend_sense = (cyc == s);
    end
    out_req = 1'b0; change_req = 2'b00; vend_sense = 1'b0;
  endtask

  task automatic pulse_fault_clr();
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    m_fault = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({vend_motor, coin10_eject, coin5_eject, busy, done, fault, overrun} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 0000000",
               {vend_motor, coin10_eject, coin5_eject, busy, done, fault, overrun});
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_vend_basic();
    build_expect(1'b1, 2'b00, 3);
    run_txn(1'b1, 2'b00, 3, 1, 0, 3'b000);
    for (int i = 0; i < expq.size(); i++) begin
      n_checks++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL vend_basic cycle %0d: got %b want %b", i + 1, obs[i], expq[i]);
      end
    end
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL vend_basic_fault: got %b want 0", fault);
    end
  endtask

  task automatic test_change15();
    build_expect(1'b0, 2'b11, 0);
    run_txn(1'b0, 2'b11, 0, 1, 0, 3'b000);
    for (int i = 0; i < expq.size(); i++) begin
      n_checks++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL change15 cycle %0d: got %b want %b", i + 1, obs[i], expq[i]);
      end
    end
  endtask

  task automatic test_timeout();
    build_expect(1'b1, 2'b01, 0);
    run_txn(1'b1, 2'b01, 0, 1, 0, 3'b000);
    m_fault = m_fault | last_to;
    for (int i = 0; i < expq.size(); i++) begin
      n_checks++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %b want %b", i + 1, obs[i], expq[i]);
      end
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (fault !== m_fault) begin
      n_fail++;
      $display("FAIL timeout_fault_sticky: got %b want %b", fault, m_fault);
    end
    pulse_fault_clr();
    n_checks++;
    if (fault !== m_fault) begin
      n_fail++;
      $display("FAIL timeout_fault_clr: got %b want %b", fault, m_fault);
    end
  endtask

  task automatic test_reset_mid();
    change_req = 2'b10;
    @(negedge clock);
    change_req = 2'b00;
    @(negedge clock);
    n_checks++;
    if (coin10_eject !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: coin10 got %b want 1", coin10_eject);
    end
    #2 reset = 1'b0;
    #1;
    m_fault = 1'b0; m_overrun = 1'b0;
    n_checks++;
    if ({vend_motor, coin10_eject, coin5_eject, busy, done, fault, overrun} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want 0000000",
               {vend_motor, coin10_eject, coin5_eject, busy, done, fault, overrun});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_checks++;
      if ({vend_motor, coin10_eject, coin5_eject, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_mid_idle cycle %0d: got %b want 00000", i,
                 {vend_motor, coin10_eject, coin5_eject, busy, done});
      end
    end
  endtask

  task automatic test_overrun();
    int dones;
    build_expect(1'b1, 2'b00, 5);
    run_txn(1'b1, 2'b00, 5, 1, 3, 3'b010);
    m_overrun = 1'b1;
    dones = 0;
    for (int i = 0; i < expq.size(); i++) begin
      dones += int'(obs[i][0]);
      n_checks++;
      if (obs[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL overrun_seq cycle %0d: got %b want %b", i + 1, obs[i], expq[i]);
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL overrun_done_count: got %0d want 1", dones);
    end
    n_checks++;
    if (overrun !== m_overrun) begin
      n_fail++;
      $display("FAIL overrun_set: got %b want %b", overrun, m_overrun);
    end
    pulse_fault_clr();
    n_checks++;
    if (overrun !== m_overrun) begin
      n_fail++;
      $display("FAIL overrun_clr: got %b want %b", overrun, m_overrun);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      build_expect(1'b1, 2'b00, 2);
      run_txn(1'b1, 2'b00, 2, (t == 0) ? 3 : 1, 0, 3'b000);
      for (int i = 0; i < expq.size(); i++) begin
        n_checks++;
        if (obs[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL back_to_back txn %0d cycle %0d: got %b want %b", t, i + 1, obs[i], expq[i]);
        end
      end
      n_checks++;
      if (overrun !== m_overrun) begin
        n_fail++;
        $display("FAIL back_to_back_overrun txn %0d: got %b want %b", t, overrun, m_overrun);
      end
    end
  endtask

  task automatic test_random();
    bit v;
    bit [1:0] c;
    int s, hold, inj_at, body;
    logic [2:0] inj_code;
    for (int n = 0; n < 16; n++) begin
      v = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      if (!v && c == 2'b00) c = 2'b01;
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 70));
      hold = int'($urandom_range(1, 3));
      build_expect(v, c, s);
      body = expq.size() - 2;
      inj_at = 0;
      inj_code = 3'b000;
      if ($urandom_range(0, 2) == 0) begin
        inj_at = int'($urandom_range(hold + 1, body));
        inj_code = 3'($urandom_range(1, 7));
        m_overrun = 1'b1;
      end
      m_fault = m_fault | last_to;
      run_txn(v, c, s, hold, inj_at, inj_code);
      for (int i = 0; i < expq.size(); i++) begin
        n_checks++;
        if (obs[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL random txn %0d (v=%0b c=%b s=%0d) cycle %0d: got %b want %b",
                   n, v, c, s, i + 1, obs[i], expq[i]);
        end
      end
      n_checks++;
      if ({fault, overrun} !== {m_fault, m_overrun}) begin
        n_fail++;
        $display("FAIL random_flags txn %0d: got %b want %b", n, {fault, overrun}, {m_fault, m_overrun});
      end
      if ($urandom_range(0, 1) == 1) pulse_fault_clr();
    end
  endtask

  initial begin
    test_reset();
    test_vend_basic();
    test_change15();
    test_timeout();
    test_reset_mid();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
